// File: rtl/otter_lsu_align_pkg.sv
// Shared constants for the OTTER load/store alignment unit:
// funct3 codes, mcause selectors, LSU state encodings and access sizes.
package otter_lsu_align_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [3:0] MCAUSE_SEL_INVLD_INSTRN        = 4'd2;
  localparam logic [3:0] MCAUSE_SEL_LOAD_ADDR_MISALIGN  = 4'd4;
  localparam logic [3:0] MCAUSE_SEL_LOAD_ACCESS_FAULT   = 4'd5;
  localparam logic [3:0] MCAUSE_SEL_STORE_ADDR_MISALIGN = 4'd6;
  localparam logic [3:0] MCAUSE_SEL_STORE_ACCESS_FAULT  = 4'd7;

  localparam logic [2:0] LSU_ST_IDLE  = 3'd0;
  localparam logic [2:0] LSU_ST_REQ0  = 3'd1;
  localparam logic [2:0] LSU_ST_WAIT0 = 3'd2;
  localparam logic [2:0] LSU_ST_REQ1  = 3'd3;
  localparam logic [2:0] LSU_ST_WAIT1 = 3'd4;
  localparam logic [2:0] LSU_ST_DONE  = 3'd5;
  localparam logic [2:0] LSU_ST_EXCP  = 3'd6;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  function automatic logic [2:0] lsu_size(input logic [1:0] sz);
    logic [2:0] s;
    case (sz)
      2'b00:   s = SIZE_B;
      2'b01:   s = SIZE_H;
      2'b10:   s = SIZE_W;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic lsu_f3_ok(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) ||
             (f3 == FUNCT3_SW);
    return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) ||
           (f3 == FUNCT3_LW) || (f3 == FUNCT3_LBU) ||
           (f3 == FUNCT3_LHU);
  endfunction

endpackage

// File: rtl/otter_lsu_align_lane.sv
// Byte-lane logic: byte enables, store data shift, load merge
// across two bus words and sign/zero extension.
module otter_lsu_align_lane
  import otter_lsu_align_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [2:0]  size;
  logic [7:0]  base;
  logic [7:0]  m;
  logic [63:0] w;
  logic [31:0] mrg;

  always_comb begin
    size = lsu_size(funct3[1:0]);
    base = 8'h00;
    unique case (1'b1)
      (size == SIZE_B): base = 8'h01;
      (size == SIZE_H): base = 8'h03;
      (size == SIZE_W): base = 8'h0f;
      default:          base = 8'h00;
    endcase
    m      = base << off;
    be0    = m[3:0];
    be1    = m[7:4];
    w      = {32'h0, wdata} << {off, 3'b000};
    wdata0 = w[31:0];
    wdata1 = w[63:32];
  end

  // Bytes beyond the access width may come from the unused word;
  // the extension below discards them.
  always_comb begin
    mrg   = 32'({rdata1, rdata0} >> {off, 3'b000});
    rdata = mrg;
    unique case (1'b1)
      (funct3 == FUNCT3_LB):
        rdata = {{24{mrg[7]}}, mrg[7:0]};
      (funct3 == FUNCT3_LH):
        rdata = {{16{mrg[15]}}, mrg[15:0]};
      (funct3 == FUNCT3_LBU):
        rdata = {24'h0, mrg[7:0]};
      (funct3 == FUNCT3_LHU):
        rdata = {16'h0, mrg[15:0]};
      default:
        rdata = mrg;
    endcase
  end

endmodule

// File: rtl/otter_lsu_align.sv
// Load/store alignment engine: aligned, split or trapped accesses.
// Optional OTTER_LSU_ALIGN_STATS_EN adds split/trap counters.
module otter_lsu_align
  import otter_lsu_align_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [31:0]     i_req_wdata,
  output logic            o_rsp_valid,
  output logic [31:0]     o_rsp_rdata,
  output logic            o_excp_valid,
  output logic [3:0]      o_excp_sel,
  output logic [XLEN-1:0] o_trap_mtval,
  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [31:0]     o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata,
  input  logic            i_mem_err
`ifdef OTTER_LSU_ALIGN_STATS_EN
  ,
  output logic [31:0]     o_split_cnt,
  output logic [31:0]     o_trap_cnt
`endif
);

  logic [2:0]      state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic            cross_q;
  logic [31:0]     rdata0_q;
  logic [31:0]     rdata1_q;
  logic [3:0]      sel_q;
  logic [XLEN-1:0] mtval_q;

  logic [2:0]      req_size;
  logic [1:0]      req_off;
  logic            req_ok;
  logic            req_mis;
  logic            req_cross;
  logic            in_req;
  logic            first;
  logic            resp;
  logic [XLEN-1:0] base_addr;

  logic [3:0]      be0;
  logic [3:0]      be1;
  logic [31:0]     wd0;
  logic [31:0]     wd1;
  logic [31:0]     ld_data;

  always_comb begin
    req_size  = lsu_size(i_req_funct3[1:0]);
    req_off   = i_req_addr[1:0];
    req_ok    = lsu_f3_ok(i_req_we, i_req_funct3);
    req_mis   = ((req_size == SIZE_H) && req_off[0]) ||
                ((req_size == SIZE_W) && (req_off != 2'b00));
    req_cross = (({1'b0, req_off} + req_size) > 3'd4);
    in_req    = (state == LSU_ST_REQ0) ||
                (state == LSU_ST_REQ1);
    first     = (state == LSU_ST_REQ0) ||
                (state == LSU_ST_WAIT0);
    // A response may ride along with the accepting cycle.
    resp      = (in_req && i_mem_ready && i_mem_rvalid) ||
                (((state == LSU_ST_WAIT0) ||
                  (state == LSU_ST_WAIT1)) && i_mem_rvalid);
    base_addr = {addr_q[XLEN-1:2], 2'b00};
  end

  otter_lsu_align_lane u_lane (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .rdata0 (rdata0_q),
    .rdata1 (rdata1_q),
    .be0    (be0),
    .be1    (be1),
    .wdata0 (wd0),
    .wdata1 (wd1),
    .rdata  (ld_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= LSU_ST_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      cross_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      sel_q    <= '0;
      mtval_q  <= '0;
    end else begin
      unique case (state)
        LSU_ST_IDLE: begin
          if (i_req_valid) begin
            we_q    <= i_req_we;
            f3_q    <= i_req_funct3;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            cross_q <= req_cross;
            if (!req_ok) begin
              state   <= LSU_ST_EXCP;
              sel_q   <= MCAUSE_SEL_INVLD_INSTRN;
              mtval_q <= '0;
            end else if (req_mis && (MISALIGN_SPLIT == 0)) begin
              state   <= LSU_ST_EXCP;
              sel_q   <= i_req_we ?
                         MCAUSE_SEL_STORE_ADDR_MISALIGN :
                         MCAUSE_SEL_LOAD_ADDR_MISALIGN;
              mtval_q <= i_req_addr;
            end else begin
              state <= LSU_ST_REQ0;
            end
          end
        end
        LSU_ST_REQ0:
          if (i_mem_ready) state <= LSU_ST_WAIT0;
        LSU_ST_REQ1:
          if (i_mem_ready) state <= LSU_ST_WAIT1;
        LSU_ST_WAIT0, LSU_ST_WAIT1: begin
        end
        LSU_ST_DONE, LSU_ST_EXCP: begin
          state   <= LSU_ST_IDLE;
          sel_q   <= '0;
          mtval_q <= '0;
        end
        default: state <= LSU_ST_IDLE;
      endcase
      if (resp) begin
        if (i_mem_err) begin
          state   <= LSU_ST_EXCP;
          sel_q   <= we_q ? MCAUSE_SEL_STORE_ACCESS_FAULT :
                            MCAUSE_SEL_LOAD_ACCESS_FAULT;
          mtval_q <= addr_q;
        end else if (first) begin
          rdata0_q <= i_mem_rdata;
          state    <= cross_q ? LSU_ST_REQ1 : LSU_ST_DONE;
        end else begin
          rdata1_q <= i_mem_rdata;
          state    <= LSU_ST_DONE;
        end
      end
    end
  end

  always_comb begin
    o_req_ready  = (state == LSU_ST_IDLE) && !i_rst;
    o_mem_valid  = in_req;
    o_mem_we     = in_req && we_q;
    o_mem_addr   = '0;
    o_mem_be     = 4'h0;
    o_mem_wdata  = '0;
    if (state == LSU_ST_REQ0) begin
      o_mem_addr  = base_addr;
      o_mem_be    = be0;
      o_mem_wdata = wd0;
    end else if (state == LSU_ST_REQ1) begin
      o_mem_addr  = base_addr + XLEN'(4);
      o_mem_be    = be1;
      o_mem_wdata = wd1;
    end
    o_rsp_valid  = (state == LSU_ST_DONE);
    o_rsp_rdata  = (o_rsp_valid && !we_q) ? ld_data : 32'h0;
    o_excp_valid = (state == LSU_ST_EXCP);
    o_excp_sel   = o_excp_valid ? sel_q : 4'h0;
    o_trap_mtval = o_excp_valid ? mtval_q : '0;
  end

`ifdef OTTER_LSU_ALIGN_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_split_cnt <= '0;
      o_trap_cnt  <= '0;
    end else begin
      if ((state == LSU_ST_DONE) && cross_q &&
          (o_split_cnt != 32'hffff_ffff))
        o_split_cnt <= o_split_cnt + 32'd1;
      // EXCP lasts exactly one cycle, so this counts entries.
      if ((state == LSU_ST_EXCP) &&
          (o_trap_cnt != 32'hffff_ffff))
        o_trap_cnt <= o_trap_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_lsu_align.sv
// Scoreboard bench for otter_lsu_align: byte-level memory model,
// directed cases, random traffic, reset abort, and a no-split instance.
module tb_otter_lsu_align;

  localparam logic [3:0] C_ILL  = 4'd2;
  localparam logic [3:0] C_LMIS = 4'd4;
  localparam logic [3:0] C_LAF  = 4'd5;
  localparam logic [3:0] C_SMIS = 4'd6;
  localparam logic [3:0] C_SAF  = 4'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 0, req_ready, req_we = 0;
  logic [2:0]  req_f3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, excp_valid;
  logic [31:0] rsp_rdata, mtval;
  logic [3:0]  excp_sel;
  logic        mem_valid, mem_we;
  logic        mem_ready = 0, mem_rvalid = 0, mem_err = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_be;

  logic        z_valid = 0, z_ready, z_we = 0;
  logic [2:0]  z_f3 = 0;
  logic [31:0] z_addr = 0;
  logic        z_rsp_valid, z_excp_valid, z_mem_valid, z_mem_we;
  logic [31:0] z_rsp_rdata, z_mtval, z_mem_addr, z_mem_wdata;
  logic [3:0]  z_excp_sel, z_mem_be;
  logic        z_rv;
  int          z_bus_seen = 0;

`ifdef OTTER_LSU_ALIGN_STATS_EN
  logic [31:0] split_cnt, trap_cnt, z_split_cnt, z_trap_cnt;
`endif

  otter_lsu_align #(.XLEN(32), .MISALIGN_SPLIT(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_funct3(req_f3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_excp_valid(excp_valid), .o_excp_sel(excp_sel),
    .o_trap_mtval(mtval),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .i_mem_err(mem_err)
`ifdef OTTER_LSU_ALIGN_STATS_EN
    , .o_split_cnt(split_cnt), .o_trap_cnt(trap_cnt)
`endif
  );

  otter_lsu_align #(.XLEN(32), .MISALIGN_SPLIT(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(z_valid), .o_req_ready(z_ready),
    .i_req_we(z_we), .i_req_funct3(z_f3),
    .i_req_addr(z_addr), .i_req_wdata(32'h0),
    .o_rsp_valid(z_rsp_valid), .o_rsp_rdata(z_rsp_rdata),
    .o_excp_valid(z_excp_valid), .o_excp_sel(z_excp_sel),
    .o_trap_mtval(z_mtval),
    .o_mem_valid(z_mem_valid), .i_mem_ready(1'b1),
    .o_mem_we(z_mem_we), .o_mem_addr(z_mem_addr),
    .o_mem_be(z_mem_be), .o_mem_wdata(z_mem_wdata),
    .i_mem_rvalid(z_rv), .i_mem_rdata(32'h8899aabb),
    .i_mem_err(1'b0)
`ifdef OTTER_LSU_ALIGN_STATS_EN
    , .o_split_cnt(z_split_cnt), .o_trap_cnt(z_trap_cnt)
`endif
  );

  // zero-wait responder for the no-split instance
  always @(posedge clk or posedge rst)
    if (rst) z_rv <= 1'b0;
    else     z_rv <= z_mem_valid;
  always @(posedge clk) if (z_mem_valid) z_bus_seen++;

  typedef struct {
    logic        excp;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] mtval;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  logic [31:0] mem [logic [31:0]];
  int bus_mode = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9e3779b1) ^ 32'h5a5a1234;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // Reference model: bytes addr..addr+size-1, grouped by bus word.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic e0, input logic e1,
                       input logic chk_lat);
    exp_t e;
    beat_t b0, b1;
    int sz, n;
    logic ok, two;
    logic [31:0] a, wa0, v, byt, d0, d1;
    logic [3:0] be0, be1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      return;
    end
    ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) :
              (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    wa0 = addr & 32'hffff_fffc;
    be0 = 0; be1 = 0; d0 = 0; d1 = 0; v = 0;
    for (int i = 0; i < sz; i++) begin
      a   = addr + i;
      byt = (mem_rd(a & 32'hffff_fffc) >> (8 * a[1:0])) & 32'hff;
      v   = v | (byt << (8 * i));
      if ((a & 32'hffff_fffc) == wa0) begin
        be0[a[1:0]] = 1'b1;
        d0 = d0 | (((wd >> (8 * i)) & 32'hff) << (8 * a[1:0]));
      end else begin
        be1[a[1:0]] = 1'b1;
        d1 = d1 | (((wd >> (8 * i)) & 32'hff) << (8 * a[1:0]));
      end
    end
    if (f3 == 3'd0 && v[7])  v = v | 32'hffff_ff00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hffff_0000;
    two = (be1 != 0);
    e.excp = 0; e.data = 0; e.sel = 0; e.mtval = 0; e.lat = 0;
    if (!ok) begin
      e.excp = 1; e.sel = C_ILL; e.lat = 1;
    end else begin
      b0 = '{we, wa0, be0, d0, e0};
      b1 = '{we, wa0 + 32'd4, be1, d1, e1};
      beat_q.push_back(b0);
      if (two && !e0) beat_q.push_back(b1);
      if (e0 || (two && e1)) begin
        e.excp  = 1;
        e.sel   = we ? C_SAF : C_LAF;
        e.mtval = addr;
        e.lat   = e0 ? 3 : 5;
      end else begin
        e.data = we ? 32'h0 : v;
        e.lat  = two ? 5 : 3;
      end
    end
    if (!chk_lat) e.lat = 0;
    e.t0 = cyc;
    exp_q.push_back(e);
    req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid || excp_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rsp=%0b excp=%0b want none",
                     rsp_valid, excp_valid);
          end else begin
            e = exp_q.pop_front();
            check("rsp_kind", {rsp_valid, excp_valid},
                  {~e.excp, e.excp});
            if (e.excp) begin
              check("excp_sel", excp_sel, e.sel);
              check("excp_mtval", mtval, e.mtval);
            end else begin
              check("rsp_rdata", rsp_rdata, e.data);
            end
            if (e.lat != 0) check("latency", cyc - e.t0, e.lat);
          end
        end else begin
          check("idle_zero", rsp_rdata | mtval | {28'h0, excp_sel}, 0);
        end
      end
    end
  end

  // bus responder
  initial begin
    beat_t b;
    logic pend, perr, er;
    logic [31:0] prd, rd, w, mask;
    int cnt;
    pend = 0; perr = 0; prd = 0; cnt = 0;
    forever begin
      @(negedge clk);
      mem_ready = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
      if (rst) begin
        pend = 0;
      end else if (pend) begin
        if (cnt == 0) begin
          mem_rvalid = 1; mem_rdata = prd; mem_err = perr; pend = 0;
        end else cnt--;
      end else if (mem_valid &&
                   (bus_mode == 0 || $urandom_range(0, 2) != 0)) begin
        mem_ready = 1;
        er = 0;
        rd = $urandom;
        if (beat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %h want none", mem_addr);
        end else begin
          b = beat_q.pop_front();
          check("beat_we", mem_we, b.we);
          check("beat_addr", mem_addr, b.addr);
          check("beat_be", mem_be, b.be);
          mask = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
          if (b.we) check("beat_wdata", mem_wdata & mask, b.wdata);
          er = b.err;
          rd = mem_rd(b.addr);
          if (b.we && !er) begin
            w = rd;
            for (int j = 0; j < 4; j++)
              if (b.be[j]) w[8*j +: 8] = b.wdata[8*j +: 8];
            mem[b.addr] = w;
          end
        end
        if (bus_mode == 1 && $urandom_range(0, 1) == 1) begin
          mem_rvalid = 1; mem_rdata = rd; mem_err = er;
        end else begin
          pend = 1; prd = rd; perr = er;
          cnt = (bus_mode == 0) ? 0 : $urandom_range(0, 2);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [2:0] lds [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    int n, t0;
    #1;
    check("rst_outputs", {req_ready, rsp_valid, excp_valid, mem_valid},
          0);
    check("rst_data", rsp_rdata | mtval | mem_addr | mem_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    bus_mode = 0;
    mem[32'h1000] = 32'hdeadbeef;
    issue(0, 3'd2, 32'h1000, 32'h0, 0, 0, 1);
    mem[32'h1000] = 32'h44332211;
    mem[32'h1004] = 32'h88776655;
    issue(0, 3'd2, 32'h1002, 32'h0, 0, 0, 1);
    issue(1, 3'd1, 32'h2003, 32'h1234abcd, 0, 0, 1);
    issue(0, 3'd5, 32'h2003, 32'h0, 0, 0, 1);
    issue(0, 3'd0, 32'h1007, 32'h0, 0, 0, 1);
    issue(0, 3'd1, 32'h1001, 32'h0, 0, 0, 1);
    issue(0, 3'd2, 32'hffff_fffe, 32'h0, 1, 0, 1);
    issue(1, 3'd2, 32'h1006, 32'hcafef00d, 0, 1, 1);
    issue(0, 3'd3, 32'h1000, 32'h0, 0, 0, 1);
    issue(1, 3'd4, 32'h1000, 32'h0, 0, 0, 1);

    bus_mode = 1;
    for (int k = 0; k < 300; k++) begin
      we = $urandom_range(0, 1) == 1;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8)
        f3 = we ? 3'($urandom_range(0, 2)) : lds[$urandom_range(0, 4)];
      addr = 32'h1000 + $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0)
        addr = 32'hffff_fffc + $urandom_range(0, 3);
      issue(we, f3, addr, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");

    // reset while the second beat is outstanding
    bus_mode = 0;
    issue(0, 3'd2, 32'h1002, 32'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("in_wait1", {req_ready, mem_valid, rsp_valid}, 0);
    check("beats_used", beat_q.size(), 0);
    #1 rst = 1;
    #1;
    check("abort_outputs",
          {req_ready, rsp_valid, excp_valid, mem_valid, mem_be}, 0);
    check("abort_data", rsp_rdata | mtval | mem_addr | mem_wdata, 0);
    exp_q.delete();
    beat_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("ready_after_abort", req_ready, 1);
    repeat (6) @(negedge clk);
    issue(0, 3'd4, 32'h1007, 32'h0, 0, 0, 1);
    repeat (5) @(negedge clk);

    // no-split instance
    check("z_ready", z_ready, 1);
    z_we = 0; z_f3 = 3'd1; z_addr = 32'h1001; z_valid = 1;
    @(negedge clk);
    z_valid = 0;
    check("z_lh_excp", z_excp_valid, 1);
    check("z_lh_sel", z_excp_sel, C_LMIS);
    check("z_lh_mtval", z_mtval, 32'h1001);
    @(negedge clk);
    z_we = 1; z_f3 = 3'd2; z_addr = 32'h2002; z_valid = 1;
    @(negedge clk);
    z_valid = 0;
    check("z_sw_excp", z_excp_valid, 1);
    check("z_sw_sel", z_excp_sel, C_SMIS);
    check("z_sw_mtval", z_mtval, 32'h2002);
    check("z_no_bus", z_bus_seen, 0);
    @(negedge clk);
    z_we = 0; z_f3 = 3'd4; z_addr = 32'h1003; z_valid = 1;
    t0 = cyc;
    @(negedge clk);
    z_valid = 0;
    n = 0;
    while (!z_rsp_valid && !z_excp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("z_lbu_valid", z_rsp_valid, 1);
    check("z_lbu_data", z_rsp_rdata, 32'h88);
    check("z_lbu_lat", cyc - t0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_lsu_align.md
Name: otter_lsu_align

Overview:
- Load/store alignment unit between the core's memory stage and the 32-bit data bus.
- Replaces the purely combinational misalignment check with a sequential engine.
- Aligned accesses pass through as a single bus beat.
- Misaligned accesses either trap (mcause 4/6, mtval = address) or, when split mode is enabled, are split into two word-aligned beats that are merged and extended internally.
- Also reports bus access faults as exceptions.

Parameters:
- XLEN, 32: address width and mtval width; must be ≥ 32.
- MISALIGN_SPLIT, 1: 1 = split word-crossing misaligned accesses into two beats; 0 = trap on any misaligned access.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  unit idle; a request is accepted when i_req_valid && o_req_ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32 load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_req_addr  in  XLEN  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  one-cycle pulse when the access completes without exception
- o_rsp_rdata  out  32  extended load data; 0 for stores
- o_excp_valid  out  1  one-cycle pulse when the access ends in an exception
- o_excp_sel  out  4  MCAUSE_SEL_* code
- o_trap_mtval  out  XLEN  faulting address
- o_mem_valid  out  1  bus request valid
- i_mem_ready  in  1  bus request accepted
- o_mem_we  out  1  bus write
- o_mem_addr  out  XLEN  word-aligned bus address, bits [1:0] = 0
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-positioned write data
- i_mem_rvalid  in  1  bus response; exactly one per accepted beat, loads and stores alike
- i_mem_rdata  in  32  bus read data
- i_mem_err  in  1  access fault, qualified by i_mem_rvalid

Behaviour:
- Reset (async, i_rst=1):
  - state = IDLE.
  - All outputs 0, including o_req_ready, which is forced 0 while i_rst is high.
  - Reset mid-transaction abandons the access with no response; the bus shares the same reset.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, EXCP. o_req_ready = (state == IDLE).
- Size from funct3: B = 1, H = 2, W = 4 bytes. off = addr[1:0].
  - misaligned = (H && off[0]) || (W && off != 0).
  - cross = off + size > 4.
- Invalid funct3 (loads 011/110/111, stores ≥ 011) → EXCP with MCAUSE_SEL_INVLD_INSTRN, mtval = 0.
- IDLE on accept:
  - invalid funct3 → EXCP.
  - misaligned and MISALIGN_SPLIT = 0 → EXCP; sel = LOAD/STORE_ADDR_MISALIGN; mtval = addr.
  - otherwise → REQ0.
  - Request fields are latched at accept.
- Misaligned but non-crossing accesses (e.g. LH at off = 1) with MISALIGN_SPLIT = 1 use a single beat.
- REQ0 / REQ1:
  - o_mem_valid = 1; address, be and wdata are held stable until i_mem_ready.
  - Next state is WAIT0 / WAIT1.
  - i_mem_rvalid in the same cycle as i_mem_ready is legal and is handled as a response.
- Lane rules:
  - m = ((1 << size) − 1) << off, 8 bits wide. beat0 be = m[3:0], beat1 be = m[7:4].
  - w = wdata << 8·off, 64 bits wide. beat0 data = w[31:0], beat1 data = w[63:32].
  - beat0 address = {addr[XLEN-1:2], 2'b00}; beat1 address = beat0 + 4, wrapping modulo 2^XLEN.
- WAIT0 on rvalid:
  - err → EXCP with LOAD/STORE_ACCESS_FAULT; mtval = original addr; beat1 is never issued.
  - else capture rdata0, then go to REQ1 if cross, otherwise DONE.
- WAIT1 on rvalid:
  - err → EXCP (same codes; mtval = original addr).
  - else capture rdata1 and go to DONE.
- DONE:
  - o_rsp_valid = 1 for one cycle.
  - rdata = ({rdata1, rdata0} >> 8·off)[31:0], sign- or zero-extended per funct3.
  - Then IDLE.
- EXCP: o_excp_valid = 1 for one cycle with o_excp_sel and o_trap_mtval; then IDLE.
- o_excp_sel and o_trap_mtval are 0 whenever o_excp_valid = 0. o_rsp_rdata is 0 whenever o_rsp_valid = 0.
- Latency with a zero-wait bus: accept at T, o_mem_valid at T+1, o_rsp_valid at T+3 for one beat or T+5 for two beats. Exceptions detected at accept pulse at T+1.

Optional Feature:
- Macro OTTER_LSU_ALIGN_STATS_EN.
- Defined: adds outputs o_split_cnt[31:0] (incremented on every two-beat access reaching DONE) and o_trap_cnt[31:0] (incremented on every EXCP entry). Both saturate at 0xFFFFFFFF and are reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- otter_defines.vh gains:
  - MCAUSE_SEL_LOAD_ACCESS_FAULT and MCAUSE_SEL_STORE_ACCESS_FAULT.
  - State encodings LSU_ST_*.
  - Size constants.
- Existing FUNCT3_* and MCAUSE_SEL_* constants are reused.
- One sub-module, otter_lsu_align_lane: combinational byte-enable generation, write shift, read merge and extension.

Test Plan:
- LW 0x1000, rdata 0xDEADBEEF → one beat, be = 1111, o_rsp_rdata = 0xDEADBEEF at T+3.
- LW 0x1002 with SPLIT = 1; bus words [0x1000] = 0x44332211, [0x1004] = 0x88776655 → beats at 0x1000 (be = 1100) and 0x1004 (be = 0011); rdata = 0x66554433.
- SH 0x2003, wdata 0xABCD, SPLIT = 1 → beat0 be = 1000, data 0xCD000000; beat1 at 0x2004, be = 0001, data 0x000000AB.
- LH 0x1001 with SPLIT = 0 → no bus activity; o_excp_valid at T+1, sel = LOAD_ADDR_MISALIGN, mtval = 0x1001.
- LW 0xFFFFFFFE with SPLIT = 1 and i_mem_err on beat0 → single beat at 0xFFFFFFFC; sel = LOAD_ACCESS_FAULT, mtval = 0xFFFFFFFE; no beat to 0x0.
- Assert i_rst during WAIT1 → all outputs 0 immediately; after release, the unit is IDLE with o_req_ready = 1 and no stale response.
